// File: rtl/agc_io_unit.sv
// agc_io_unit: eight-channel 15-bit AGC I/O block with latches, synced inputs, edge flags, timer and irq.
// Define IO_LOOPBACK_EN to make ch3 read the ch1 latch directly (core self-test) instead of ext_in0.
module agc_io_unit #(
    parameter int          PRESCALE = 16,
    parameter logic [14:0] ID_VALUE = 15'h0AC5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  IO_read_sel,
    output logic [14:0] IO_read_data,
    input  logic        IO_write_en,
    input  logic [2:0]  IO_write_sel,
    input  logic [14:0] IO_write_data,
    input  logic [14:0] ext_in0,
    input  logic [14:0] ext_in1,
    output logic [14:0] out_ch1,
    output logic [14:0] out_ch2,
    output logic        irq
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [14:0]   r_ch0, r_ch1, r_ch2, r_ch4, r_ch5, r_ch6;
    logic [14:0]   r_s0a, r_s0b, r_s1a, r_s1b, r_s1prev;
    logic [PW-1:0] r_presc;
    logic [14:0]   w_ch3, w_rise, w_clr;
    logic          w_term;

`ifdef IO_LOOPBACK_EN
    assign w_ch3 = r_ch1;
`else
    assign w_ch3 = r_s0b;
`endif
    assign w_rise  = r_s1b & ~r_s1prev;
    assign w_clr   = (IO_write_en && IO_write_sel == 3'd4) ? IO_write_data : 15'd0;
    assign w_term  = (r_presc == P_LAST);
    assign out_ch1 = r_ch1;
    assign out_ch2 = r_ch2;
    assign irq     = |(r_ch4 & r_ch6);

    always_comb begin
        IO_read_data = ID_VALUE;
        case (IO_read_sel)
            3'd0: IO_read_data = r_ch0;
            3'd1: IO_read_data = r_ch1;
            3'd2: IO_read_data = r_ch2;
            3'd3: IO_read_data = w_ch3;
            3'd4: IO_read_data = r_ch4;
            3'd5: IO_read_data = r_ch5;
            3'd6: IO_read_data = r_ch6;
            default: IO_read_data = ID_VALUE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ch0    <= '0;
            r_ch1    <= '0;
            r_ch2    <= '0;
            r_ch4    <= '0;
            r_ch5    <= '0;
            r_ch6    <= '0;
            r_s0a    <= '0;
            r_s0b    <= '0;
            r_s1a    <= '0;
            r_s1b    <= '0;
            r_s1prev <= '0;
            r_presc  <= '0;
        end else begin
            r_s0a    <= ext_in0;
            r_s0b    <= r_s0a;
            r_s1a    <= ext_in1;
            r_s1b    <= r_s1a;
            r_s1prev <= r_s1b;
            // set wins over write-1-to-clear on the same edge
            r_ch4    <= (r_ch4 & ~w_clr) | w_rise;
            if (IO_write_en && IO_write_sel == 3'd0) r_ch0 <= IO_write_data;
            if (IO_write_en && IO_write_sel == 3'd1) r_ch1 <= IO_write_data;
            if (IO_write_en && IO_write_sel == 3'd2) r_ch2 <= IO_write_data;
            if (IO_write_en && IO_write_sel == 3'd6) r_ch6 <= IO_write_data;
            if (IO_write_en && IO_write_sel == 3'd5) begin
                r_ch5   <= IO_write_data;
                r_presc <= '0;
            end else if (w_term) begin
                r_ch5   <= r_ch5 + 15'd1;
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_agc_io_unit.sv
// tb_agc_io_unit: directed self-checking bench for agc_io_unit.
module tb_agc_io_unit;
    localparam int P = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  IO_read_sel = '0;
    logic [14:0] IO_read_data;
    logic        IO_write_en = 1'b0;
    logic [2:0]  IO_write_sel = '0;
    logic [14:0] IO_write_data = '0;
    logic [14:0] ext_in0 = '0;
    logic [14:0] ext_in1 = '0;
    logic [14:0] out_ch1, out_ch2;
    logic        irq;
    int total = 0;
    int bad = 0;

    agc_io_unit #(.PRESCALE(P), .ID_VALUE(15'h0AC5)) dut (
        .clock(clock), .reset_n(reset_n),
        .IO_read_sel(IO_read_sel), .IO_read_data(IO_read_data),
        .IO_write_en(IO_write_en), .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data),
        .ext_in0(ext_in0), .ext_in1(ext_in1),
        .out_ch1(out_ch1), .out_ch2(out_ch2), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [2:0] s);
        IO_read_sel = s;
        #1;
    endtask

    task automatic wr(input logic [2:0] s, input logic [14:0] d);
        IO_write_en = 1'b1;
        IO_write_sel = s;
        IO_write_data = d;
        tick();
        IO_write_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] e;
        reset_n = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 8; s++) begin
            rd(3'(s));
            e = (s == 7) ? 15'h0AC5 : 15'h0000;
            total++; if (IO_read_data !== e) begin bad++; $display("FAIL reset_ch%0d got=%h exp=%h", s, IO_read_data, e); end
        end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        total++; if (out_ch1 !== 15'h0) begin bad++; $display("FAIL reset_out1 got=%h exp=0000", out_ch1); end
        total++; if (out_ch2 !== 15'h0) begin bad++; $display("FAIL reset_out2 got=%h exp=0000", out_ch2); end
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_latches();
        IO_read_sel = 3'd1;
        IO_write_en = 1'b1;
        IO_write_sel = 3'd1;
        IO_write_data = 15'h1234;
        #1;
        total++; if (IO_read_data !== 15'h0000) begin bad++; $display("FAIL same_cycle_ch1 got=%h exp=0000", IO_read_data); end
        tick();
        IO_write_en = 1'b0;
        total++; if (out_ch1 !== 15'h1234) begin bad++; $display("FAIL out_ch1 got=%h exp=1234", out_ch1); end
        total++; if (IO_read_data !== 15'h1234) begin bad++; $display("FAIL rd_ch1 got=%h exp=1234", IO_read_data); end
        wr(3'd2, 15'h7FFF);
        rd(3'd2);
        total++; if (out_ch2 !== 15'h7FFF) begin bad++; $display("FAIL out_ch2 got=%h exp=7fff", out_ch2); end
        total++; if (IO_read_data !== 15'h7FFF) begin bad++; $display("FAIL rd_ch2 got=%h exp=7fff", IO_read_data); end
        wr(3'd0, 15'h5555);
        rd(3'd0);
        total++; if (IO_read_data !== 15'h5555) begin bad++; $display("FAIL rd_ch0 got=%h exp=5555", IO_read_data); end
        total++; if (out_ch1 !== 15'h1234) begin bad++; $display("FAIL out_ch1_hold got=%h exp=1234", out_ch1); end
    endtask

`ifdef IO_LOOPBACK_EN
    task automatic test_ch3();
        ext_in0 = 15'h2A5A;
        rd(3'd3);
        total++; if (IO_read_data !== 15'h1234) begin bad++; $display("FAIL loop_ch3_old got=%h exp=1234", IO_read_data); end
        wr(3'd1, 15'h0F0F);
        rd(3'd3);
        total++; if (IO_read_data !== 15'h0F0F) begin bad++; $display("FAIL loop_ch3 got=%h exp=0f0f", IO_read_data); end
        tick();
        tick();
        rd(3'd3);
        total++; if (IO_read_data !== 15'h0F0F) begin bad++; $display("FAIL loop_ch3_ext got=%h exp=0f0f", IO_read_data); end
        wr(3'd3, 15'h1111);
        wr(3'd7, 15'h1111);
        rd(3'd3);
        total++; if (IO_read_data !== 15'h0F0F) begin bad++; $display("FAIL loop_ch3_wr got=%h exp=0f0f", IO_read_data); end
        rd(3'd7);
        total++; if (IO_read_data !== 15'h0AC5) begin bad++; $display("FAIL ch7_wr got=%h exp=0ac5", IO_read_data); end
    endtask
`else
    task automatic test_ch3();
        ext_in0 = 15'h2A5A;
        tick();
        rd(3'd3);
        total++; if (IO_read_data !== 15'h0000) begin bad++; $display("FAIL ch3_1clk got=%h exp=0000", IO_read_data); end
        tick();
        rd(3'd3);
        total++; if (IO_read_data !== 15'h2A5A) begin bad++; $display("FAIL ch3_2clk got=%h exp=2a5a", IO_read_data); end
        wr(3'd3, 15'h1111);
        wr(3'd7, 15'h1111);
        rd(3'd3);
        total++; if (IO_read_data !== 15'h2A5A) begin bad++; $display("FAIL ch3_wr got=%h exp=2a5a", IO_read_data); end
        rd(3'd7);
        total++; if (IO_read_data !== 15'h0AC5) begin bad++; $display("FAIL ch7_wr got=%h exp=0ac5", IO_read_data); end
    endtask
`endif

    task automatic test_edge();
        IO_read_sel = 3'd4;
        ext_in1 = 15'h0008;
        tick();
        tick();
        total++; if (IO_read_data !== 15'h0000) begin bad++; $display("FAIL ch4_early got=%h exp=0000", IO_read_data); end
        tick();
        total++; if (IO_read_data !== 15'h0008) begin bad++; $display("FAIL ch4_set got=%h exp=0008", IO_read_data); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", irq); end
        wr(3'd6, 15'h0008);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", irq); end
        wr(3'd4, 15'h0008);
        total++; if (IO_read_data !== 15'h0000) begin bad++; $display("FAIL ch4_clr got=%h exp=0000", IO_read_data); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b exp=0", irq); end
        tick();
        tick();
        tick();
        total++; if (IO_read_data !== 15'h0000) begin bad++; $display("FAIL ch4_held got=%h exp=0000", IO_read_data); end
        ext_in1 = 15'h0000;
        repeat (4) tick();
        ext_in1 = 15'h0008;
        tick();
        tick();
        wr(3'd4, 15'h0008);
        total++; if (IO_read_data !== 15'h0008) begin bad++; $display("FAIL ch4_set_wins got=%h exp=0008", IO_read_data); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins got=%b exp=1", irq); end
    endtask

    task automatic test_timer();
        IO_read_sel = 3'd5;
        wr(3'd5, 15'h7FFF);
        total++; if (IO_read_data !== 15'h7FFF) begin bad++; $display("FAIL ch5_load got=%h exp=7fff", IO_read_data); end
        repeat (P - 1) tick();
        total++; if (IO_read_data !== 15'h7FFF) begin bad++; $display("FAIL ch5_pre got=%h exp=7fff", IO_read_data); end
        tick();
        total++; if (IO_read_data !== 15'h0000) begin bad++; $display("FAIL ch5_wrap got=%h exp=0000", IO_read_data); end
        repeat (P - 1) tick();
        wr(3'd5, 15'h1234);
        total++; if (IO_read_data !== 15'h1234) begin bad++; $display("FAIL ch5_load_wins got=%h exp=1234", IO_read_data); end
        repeat (P - 1) tick();
        total++; if (IO_read_data !== 15'h1234) begin bad++; $display("FAIL ch5_presc_zeroed got=%h exp=1234", IO_read_data); end
        tick();
        total++; if (IO_read_data !== 15'h1235) begin bad++; $display("FAIL ch5_inc got=%h exp=1235", IO_read_data); end
    endtask

    task automatic test_async_reset();
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        total++; if (out_ch1 !== 15'h0) begin bad++; $display("FAIL arst_out1 got=%h exp=0000", out_ch1); end
        total++; if (out_ch2 !== 15'h0) begin bad++; $display("FAIL arst_out2 got=%h exp=0000", out_ch2); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL arst_irq got=%b exp=0", irq); end
        for (int s = 0; s < 7; s++) begin
            rd(3'(s));
            total++; if (IO_read_data !== 15'h0) begin bad++; $display("FAIL arst_ch%0d got=%h exp=0000", s, IO_read_data); end
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_latches();
        test_ch3();
        test_edge();
        test_timer();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
